// File: rtl/iterative_divider_if.sv
// Request/response bundle between the execute stage and iterative_divider.
// The master (pipeline) drives start, mode and operands. The slave (divider) returns
// busy, done and Result.
interface iterative_divider_if #(
  parameter int unsigned N = 32
);
  logic         start;
  logic [1:0]   mode;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Result;

  modport master (
    output start, mode, A, B,
    input  busy, done, Result
  );

  modport slave (
    input  start, mode, A, B,
    output busy, done, Result
  );
endinterface

// File: rtl/iterative_divider.sv
// Multi-cycle radix-2 restoring divider for RV32IM DIV/DIVU/REM/REMU.
// mode = funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
// The optional macro DIV_EARLY_OUT_EN makes divide-by-zero and signed overflow skip
// the iteration phase, which gives a latency of 2. Without it, every operation takes
// N+2 cycles.
module iterative_divider #(
  parameter int unsigned N = 32
) (
  input logic             CLK,
  input logic             RST_N,
  iterative_divider_if.slave bus
);

  localparam int unsigned CntW   = $clog2(N);
  localparam logic [N-1:0] MinNeg = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StInit, StIter, StFix} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [1:0]      mode_q, mode_d;
  logic [N-1:0]    rem_q, rem_d, quo_q, quo_d, bmag_q, bmag_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sign_q_q, sign_q_d, sign_r_q, sign_r_d;
  logic [N-1:0]    result_q, result_d;
  logic            done_q, done_d;

  logic         signed_mode, a_neg, b_neg, div_zero, ovf;
  logic [N:0]   trial;
  logic [N-1:0] rem_sh, quo_fix, rem_fix;

  assign signed_mode = ~mode_q[0];
  assign a_neg       = signed_mode & a_q[N-1];
  assign b_neg       = signed_mode & b_q[N-1];
  assign div_zero    = (b_q == '0);
  assign ovf         = signed_mode && (a_q == MinNeg) && (b_q == '1);

  // Shift {rem, quo} left by one, then trial-subtract the divisor magnitude in N+1 bits.
  assign rem_sh = {rem_q[N-2:0], quo_q[N-1]};
  assign trial  = {rem_q, quo_q[N-1]} - {1'b0, bmag_q};

  // Sign correction plus the RISC-V results for the special cases.
  always_comb begin
    quo_fix = sign_q_q ? -quo_q : quo_q;
    rem_fix = sign_r_q ? -rem_q : rem_q;
    if (div_zero) begin
      quo_fix = '1;
      rem_fix = a_q;
    end else if (ovf) begin
      quo_fix = a_q;
      rem_fix = '0;
    end
  end

  // Next-state logic and datapath for the FSM.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    bmag_d   = bmag_q;
    cnt_d    = cnt_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          mode_d  = bus.mode;
          state_d = StInit;
        end
      end
      StInit: begin
        rem_d    = '0;
        quo_d    = a_neg ? -a_q : a_q;
        bmag_d   = b_neg ? -b_q : b_q;
        sign_q_d = a_neg ^ b_neg;
        sign_r_d = a_neg;
        cnt_d    = CntW'(N - 1);
        state_d  = StIter;
`ifdef DIV_EARLY_OUT_EN
        if (div_zero || ovf) state_d = StFix;
`else
`endif
      end
      StIter: begin
        rem_d = trial[N] ? rem_sh : trial[N-1:0];
        quo_d = {quo_q[N-2:0], ~trial[N]};
        if (cnt_q == '0) state_d = StFix;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StFix: begin
        result_d = mode_q[1] ? rem_fix : quo_fix;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      bmag_q   <= '0;
      cnt_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      bmag_q   <= bmag_d;
      cnt_q    <= cnt_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = done_q;
  assign bus.Result = result_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: the bench pushes an expected result when it
// drives start, and pops and compares that entry when done arrives.
module tb_iterative_divider;

  localparam int NormLat = 34;
`ifdef DIV_EARLY_OUT_EN
  localparam int SpecLat = 2;
`else
  localparam int SpecLat = 34;
`endif

  typedef struct packed {
    logic [31:0] res;
    int          lat;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  iterative_divider_if #(.N(32)) bus ();

  iterative_divider #(.N(32)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model from SV arithmetic, with the RISC-V special cases.
  function automatic exp_t model(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    e.lat = NormLat;
    if (b == 32'd0) begin
      e.res = m[1] ? a : 32'hFFFF_FFFF;
      e.lat = SpecLat;
    end else if (!m[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = m[1] ? 32'd0 : a;
      e.lat = SpecLat;
    end else begin
      case (m)
        2'b00:   e.res = sa / sb;
        2'b01:   e.res = a / b;
        2'b10:   e.res = sa % sb;
        default: e.res = a % b;
      endcase
    end
    return e;
  endfunction

  // Drive a start pulse sampled at one rising edge; returns #1 after that edge.
  task automatic start_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.A     = a;
    bus.B     = b;
    sb_q.push_back(model(m, a, b));
    @(posedge CLK);
    #1;
    bus.start = 1'b0;
  endtask

  // Count cycles to done. Optionally inject a stray start (DIVU 100/1) at cycle pulse_at.
  task automatic wait_done(input int pulse_at, output int lat, output int busy_cnt,
                           output bit ok);
    lat = 0;
    ok = 1'b0;
    busy_cnt = bus.busy ? 1 : 0;
    while (lat < 200) begin
      @(posedge CLK);
      #1;
      lat++;
      if (lat == pulse_at) begin
        bus.start = 1'b1;
        bus.mode  = 2'b01;
        bus.A     = 32'd100;
        bus.B     = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Start one op, wait for done, pop the scoreboard.
  task automatic run_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at, output logic [31:0] res, output int lat,
                        output int busy_cnt, output bit ok, output exp_t e);
    start_op(m, a, b);
    wait_done(pulse_at, lat, busy_cnt, ok);
    res = bus.Result;
    e = sb_q.pop_front();
  endtask

  task automatic test_reset();
    #1 RST_N = 1'b0;
    #2;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Result !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b Result=%h required 0 0 00000000",
               bus.busy, bus.done, bus.Result);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Result !== 32'd0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b done=%b Result=%h required 0 0 00000000",
               bus.busy, bus.done, bus.Result);
    end
  endtask

  // Runs the op and compares Result and latency against the scoreboard.
  task automatic test_op(input string name, input logic [1:0] m, input logic [31:0] a,
                         input logic [31:0] b);
    logic [31:0] res;
    int lat, bc;
    bit ok;
    exp_t e;
    run_op(m, a, b, -1, res, lat, bc, ok, e);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout: no done within 200 cycles, required done at %0d", name, e.lat);
    end else begin
      if (res !== e.res) begin
        failures++;
        $display("FAIL %s_result: got %h required %h", name, res, e.res);
      end
      checks++;
      if (lat !== e.lat) begin
        failures++;
        $display("FAIL %s_latency: got %0d required %0d", name, lat, e.lat);
      end
    end
  endtask

  task automatic test_signed();
    test_op("div_neg7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    test_op("rem_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
  endtask

  task automatic test_unsigned();
    logic [31:0] res;
    int lat, bc;
    bit ok;
    exp_t e;
    run_op(2'b01, 32'd100, 32'd7, -1, res, lat, bc, ok, e);
    checks++;
    if (!ok || res !== 32'd14) begin
      failures++;
      $display("FAIL divu_100_7: got %h ok=%b required 0000000e", res, ok);
    end
    checks++;
    if (bc !== 34) begin
      failures++;
      $display("FAIL divu_busy_cycles: got %0d required 34", bc);
    end
    test_op("remu_100_7", 2'b11, 32'd100, 32'd7);
  endtask

  task automatic test_div_zero();
    test_op("div_5_0", 2'b00, 32'd5, 32'd0);
    test_op("divu_5_0", 2'b01, 32'd5, 32'd0);
    test_op("rem_neg5_0", 2'b10, 32'hFFFF_FFFB, 32'd0);
  endtask

  task automatic test_overflow();
    test_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    test_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    test_op("divu_min_ones", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if ($urandom_range(0, 1) == 1) b = -b;
      test_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), a, b);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat, bc, extra;
    bit ok;
    exp_t e;
    run_op(2'b01, 32'd50, 32'd5, -1, res, lat, bc, ok, e);
    checks++;
    if (!ok || res !== 32'd10) begin
      failures++;
      $display("FAIL b2b_first: got %h ok=%b required 0000000a", res, ok);
    end
    // Still in the done cycle: this start is sampled at the next edge.
    run_op(2'b01, 32'd9, 32'd3, 5, res, lat, bc, ok, e);
    checks++;
    if (!ok || res !== 32'd3) begin
      failures++;
      $display("FAIL b2b_second_result: got %h ok=%b required 00000003", res, ok);
    end
    checks++;
    if (lat !== 34) begin
      failures++;
      $display("FAIL b2b_second_latency: got %0d required 34", lat);
    end
    extra = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (bus.done || bus.busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL ignored_start: busy/done cycles after op=%0d required 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] res;
    int lat, bc;
    bit ok;
    exp_t e;
    start_op(2'b01, 32'd1000, 32'd3);
    repeat (11) begin
      @(posedge CLK);
      #1;
    end
    RST_N = 1'b0;
    #1;
    void'(sb_q.pop_front());
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Result !== 32'd0) begin
      failures++;
      $display("FAIL abort_reset: busy=%b done=%b Result=%h required 0 0 00000000",
               bus.busy, bus.done, bus.Result);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    run_op(2'b01, 32'd8, 32'd2, -1, res, lat, bc, ok, e);
    checks++;
    if (!ok || res !== 32'd4 || lat !== 34) begin
      failures++;
      $display("FAIL after_abort_divu: got %h lat=%0d ok=%b required 00000004 lat=34",
               res, lat, ok);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode  = 2'b00;
    bus.A     = '0;
    bus.B     = '0;
    test_reset();
    test_signed();
    test_unsigned();
    test_div_zero();
    test_overflow();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iterative_divider.md
# iterative_divider

Multi-cycle radix-2 restoring divider for the RV32IM M-extension; the divide-side counterpart to the pipelined multiplier. It executes DIV, DIVU, REM and REMU with RISC-V-compliant divide-by-zero and signed-overflow results. It sits beside the multiplier in the execute stage and stalls the pipeline through a start/busy/done handshake.

## Interface
- N, 32, operand and result width; must be even and at least 4.
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  2  operation, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- A  input  N  dividend; sampled with start.
- B  input  N  divisor; sampled with start.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse; Result is valid in that cycle.
- Result  output  N  quotient for modes 0x, remainder for modes 1x; holds until the next done.

## Operation
- States: IDLE, INIT, ITER, FIX.
- **IDLE**
  - On start=1, latch A, B and mode, then go to INIT.
  - start=0 leaves the state unchanged.
- **INIT**
  - Signed modes (00, 10): convert operands to magnitudes by two's complement when the MSB is set.
  - Record sign_q = A[N-1]^B[N-1] and sign_r = A[N-1]; both are 0 for unsigned modes.
  - Clear the remainder register, load the quotient register with |A|, set count = N-1, go to ITER.
- **ITER** (one bit per cycle)
  - Shift {rem, quo} left by 1 and form trial = rem_shifted - |B| in N+1 bits.
  - If trial is non-negative: rem = trial[N-1:0] and the quotient LSB = 1.
  - Otherwise keep rem_shifted and set the quotient LSB = 0.
  - At count = 0 go to FIX; otherwise decrement count.
- **FIX**
  - Negate the quotient if sign_q; negate the remainder if sign_r.
  - Register Result per mode, assert done for one cycle, return to IDLE.
- **Special cases** (forced in FIX regardless of datapath contents):
  - B = 0: quotient = all ones (-1 for DIV, 2^N-1 for DIVU); remainder = A unmodified.
  - DIV/REM with A = 0x8..0 and B = all ones: quotient = A (0x8..0); remainder = 0.
- **start during busy**: ignored, with no queuing.
- **start in the done cycle**: accepted, since the state is already IDLE. This gives back-to-back operations.

## Timing
- Reset values: busy=0, done=0, Result=0, state=IDLE, all internal registers 0.
- Reset is asynchronous. Asserting RST_N mid-operation aborts it immediately, and no done is produced.
- Normal latency, with start sampled at edge t:
  - edge t+1 enters ITER;
  - edges t+2 through t+N+1 perform the N iterations;
  - edge t+N+2 registers Result and done.
  - done is high in the cycle after edge t+N+2, i.e. N+2 cycles after the start edge (34 for N=32).
- busy rises in the cycle after edge t and falls in the same cycle that done is high.
- Result changes only on a done edge.

## Configuration
- DIV_EARLY_OUT_EN
  - **Defined**: INIT detects B = 0 or signed overflow and jumps directly to FIX. done is then high after edge t+2 (latency 2).
  - **Undefined**: special cases run the full N iterations. Latency is always N+2, with identical Result values forced in FIX.

## Test plan
- DIV A=0xFFFFFFF9 (-7), B=2 -> done at start+34, Result=0xFFFFFFFD (-3); REM of the same operands -> Result=0xFFFFFFFF (-1).
- DIVU A=100, B=7 -> Result=14; REMU -> Result=2; busy high for exactly 34 cycles.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REM 0xFFFFFFFB/0 -> 0xFFFFFFFB. Latency is 2 with DIV_EARLY_OUT_EN defined, otherwise 34.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Back-to-back: second start (DIVU 9/3) asserted in the done cycle of the first -> second done exactly 34 cycles later, Result=3. start pulses during busy are ignored.
- Reset: RST_N=0 at iteration 10 -> busy, done and Result are 0 immediately. A new DIVU 8/2 after release -> Result=4.
